// File: rtl/lc3_pkg.sv
// Shared LC-3 encodings: op classes, ALU/address-select codes, writeback codes
// and the Execute control-bus layout.
package lc3_pkg;

    localparam int unsigned WORD_W = 16;

    typedef enum logic [1:0] {
        OP_CTRL  = 2'b00,
        OP_ALU   = 2'b01,
        OP_LOAD  = 2'b10,
        OP_STORE = 2'b11
    } op_class_e;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'd0,
        ALU_AND  = 2'd1,
        ALU_NOT  = 2'd2,
        ALU_ZERO = 2'd3
    } alu_op_e;

    typedef enum logic [1:0] {
        PCS_OFF11 = 2'd0,
        PCS_OFF9  = 2'd1,
        PCS_OFF6  = 2'd2,
        PCS_ZERO  = 2'd3
    } pcsel1_e;

    typedef enum logic [1:0] {
        W_ALU  = 2'd0,
        W_MEM  = 2'd1,
        W_ADDR = 2'd2
    } wsel_e;

    // E_Control bit positions
    localparam int unsigned EC_ALU_HI   = 5;
    localparam int unsigned EC_ALU_LO   = 4;
    localparam int unsigned EC_PCS1_HI  = 3;
    localparam int unsigned EC_PCS1_LO  = 2;
    localparam int unsigned EC_PCS2     = 1;
    localparam int unsigned EC_OP2SEL   = 0;
    localparam int unsigned EC_W        = 6;

    typedef struct packed {
        alu_op_e alu_control;
        pcsel1_e pcselect1;
        logic    pcselect2;
        logic    op2select;
    } e_ctrl_t;

endpackage

// File: rtl/exec_alu.sv
// Combinational LC-3 ALU: ADD, AND, NOT, or zero.
module exec_alu
    import lc3_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] op1_i,
    input  logic [WIDTH-1:0] op2_i,
    input  alu_op_e          alu_control_i,
    output logic [WIDTH-1:0] result_c
);

    always_comb begin
        result_c = '0;
        case (alu_control_i)
            ALU_ADD:  result_c = op1_i + op2_i;
            ALU_AND:  result_c = op1_i & op2_i;
            ALU_NOT:  result_c = ~op1_i;
            default:  result_c = '0;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// LC-3 Execute stage: operand forwarding, ALU, address generation, NZP mask.
// Forwarding muxes are built only when EXEC_BYPASS_EN is defined.
module execute_stage
    import lc3_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable_execute,
    input  logic [5:0]       E_Control,
    input  logic [WIDTH-1:0] IR,
    input  logic [WIDTH-1:0] npc_in,
    input  logic [1:0]       W_Control_in,
    input  logic             Mem_Control_in,
    input  logic [WIDTH-1:0] VSR1,
    input  logic [WIDTH-1:0] VSR2,
    input  logic             bypass_alu_1,
    input  logic             bypass_alu_2,
    input  logic             bypass_mem_1,
    input  logic             bypass_mem_2,
    input  logic [WIDTH-1:0] Mem_Bypass_Val,
    output logic [2:0]       sr1,
    output logic [2:0]       sr2,
    output logic [WIDTH-1:0] aluout,
    output logic [WIDTH-1:0] pcout,
    output logic [WIDTH-1:0] M_Data,
    output logic [2:0]       NZP,
    output logic [2:0]       dr,
    output logic [WIDTH-1:0] IR_Exec,
    output logic [1:0]       W_Control_out,
    output logic             Mem_Control_out
);

    e_ctrl_t          ec;
    op_class_e        op_class;
    logic [WIDTH-1:0] op1, vsr2f, op2, alu_res;
    logic [WIDTH-1:0] addr_op, base_op;

    logic [WIDTH-1:0] aluout_q, aluout_d;
    logic [WIDTH-1:0] pcout_q, pcout_d;
    logic [WIDTH-1:0] mdata_q, mdata_d;
    logic [2:0]       nzp_q, nzp_d;
    logic [2:0]       dr_q, dr_d;
    logic [WIDTH-1:0] ir_q, ir_d;
    logic [1:0]       wctl_q, wctl_d;
    logic             mctl_q, mctl_d;

    assign ec       = e_ctrl_t'(E_Control);
    assign op_class = op_class_e'(IR[13:12]);

    // Register-file read indices; stores read the source value from IR[11:9]
    assign sr1 = IR[8:6];
    assign sr2 = (op_class == OP_STORE) ? IR[11:9] : IR[2:0];

`ifdef EXEC_BYPASS_EN
    // Youngest value wins: own aluout, then Memory-stage result, then regfile
    assign op1   = bypass_alu_1 ? aluout_q : (bypass_mem_1 ? Mem_Bypass_Val : VSR1);
    assign vsr2f = bypass_alu_2 ? aluout_q : (bypass_mem_2 ? Mem_Bypass_Val : VSR2);
`else
    logic unused_bypass_c;
    assign op1             = VSR1;
    assign vsr2f           = VSR2;
    assign unused_bypass_c = ^{bypass_alu_1, bypass_alu_2, bypass_mem_1,
                               bypass_mem_2, Mem_Bypass_Val};
`endif

    assign op2 = ec.op2select ? vsr2f : {{(WIDTH-5){IR[4]}}, IR[4:0]};

    exec_alu #(.WIDTH(WIDTH)) u_alu (
        .op1_i         (op1),
        .op2_i         (op2),
        .alu_control_i (ec.alu_control),
        .result_c      (alu_res)
    );

    always_comb begin
        addr_op = '0;
        case (ec.pcselect1)
            PCS_OFF11: addr_op = {{(WIDTH-11){IR[10]}}, IR[10:0]};
            PCS_OFF9:  addr_op = {{(WIDTH-9){IR[8]}},   IR[8:0]};
            PCS_OFF6:  addr_op = {{(WIDTH-6){IR[5]}},   IR[5:0]};
            default:   addr_op = '0;
        endcase
    end

    assign base_op = ec.pcselect2 ? npc_in : op1;

    // Next-state for the pipeline register bank
    always_comb begin
        aluout_d = aluout_q;
        pcout_d  = pcout_q;
        mdata_d  = mdata_q;
        nzp_d    = nzp_q;
        dr_d     = dr_q;
        ir_d     = ir_q;
        wctl_d   = wctl_q;
        mctl_d   = mctl_q;
        if (enable_execute) begin
            if (op_class == OP_ALU) begin
                aluout_d = alu_res;
            end
            pcout_d = addr_op + base_op;
            mdata_d = vsr2f;
            if (IR[15:12] == 4'b0000) begin
                nzp_d = IR[11:9];
            end else if (IR[15:12] == 4'b1100) begin
                nzp_d = 3'b111;
            end else begin
                nzp_d = 3'b000;
            end
            dr_d   = IR[11:9];
            ir_d   = IR;
            wctl_d = W_Control_in;
            mctl_d = Mem_Control_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            aluout_q <= '0;
            pcout_q  <= '0;
            mdata_q  <= '0;
            nzp_q    <= '0;
            dr_q     <= '0;
            ir_q     <= '0;
            wctl_q   <= '0;
            mctl_q   <= 1'b0;
        end else begin
            aluout_q <= aluout_d;
            pcout_q  <= pcout_d;
            mdata_q  <= mdata_d;
            nzp_q    <= nzp_d;
            dr_q     <= dr_d;
            ir_q     <= ir_d;
            wctl_q   <= wctl_d;
            mctl_q   <= mctl_d;
        end
    end

    assign aluout          = aluout_q;
    assign pcout           = pcout_q;
    assign M_Data          = mdata_q;
    assign NZP             = nzp_q;
    assign dr              = dr_q;
    assign IR_Exec         = ir_q;
    assign W_Control_out   = wctl_q;
    assign Mem_Control_out = mctl_q;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed cases plus randomized traffic
// checked against an instruction-level reference model.
module tb_execute_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable_execute;
    logic [5:0]  E_Control;
    logic [15:0] IR, npc_in, VSR1, VSR2, Mem_Bypass_Val;
    logic [1:0]  W_Control_in;
    logic        Mem_Control_in;
    logic        bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2;
    logic [2:0]  sr1, sr2, NZP, dr;
    logic [15:0] aluout, pcout, M_Data, IR_Exec;
    logic [1:0]  W_Control_out;
    logic        Mem_Control_out;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic [15:0] m_alu, m_pc, m_mdata, m_ir;
    logic [2:0]  m_nzp, m_dr;
    logic [1:0]  m_w;
    logic        m_mc;

    always #5 clock = ~clock;

    execute_stage dut (
        .clock           (clock),
        .reset           (reset),
        .enable_execute  (enable_execute),
        .E_Control       (E_Control),
        .IR              (IR),
        .npc_in          (npc_in),
        .W_Control_in    (W_Control_in),
        .Mem_Control_in  (Mem_Control_in),
        .VSR1            (VSR1),
        .VSR2            (VSR2),
        .bypass_alu_1    (bypass_alu_1),
        .bypass_alu_2    (bypass_alu_2),
        .bypass_mem_1    (bypass_mem_1),
        .bypass_mem_2    (bypass_mem_2),
        .Mem_Bypass_Val  (Mem_Bypass_Val),
        .sr1             (sr1),
        .sr2             (sr2),
        .aluout          (aluout),
        .pcout           (pcout),
        .M_Data          (M_Data),
        .NZP             (NZP),
        .dr              (dr),
        .IR_Exec         (IR_Exec),
        .W_Control_out   (W_Control_out),
        .Mem_Control_out (Mem_Control_out)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // sign-extend a 'bits'-wide field using plain integer arithmetic
    function automatic logic [15:0] sx(input int unsigned v, input int unsigned bits);
        int s;
        s = int'(v);
        if (v >= (32'd1 << (bits - 1))) s = s - int'(32'd1 << bits);
        return 16'(s);
    endfunction

    function automatic logic [15:0] fwd(input logic ba, input logic bm, input logic [15:0] rf,
                                        input logic [15:0] prev_alu);
`ifdef EXEC_BYPASS_EN
        if (ba) return prev_alu;
        if (bm) return Mem_Bypass_Val;
        return rf;
`else
        return (ba | bm) ? rf : rf;
`endif
    endfunction

    // One clock edge of the architectural behaviour
    task automatic model_edge();
        logic [15:0] o1, v2f, o2, res, addr, base;
        int opc;
        if (reset) begin
            m_alu = 0; m_pc = 0; m_mdata = 0; m_ir = 0;
            m_nzp = 0; m_dr = 0; m_w = 0; m_mc = 0;
        end else if (enable_execute) begin
            o1  = fwd(bypass_alu_1, bypass_mem_1, VSR1, m_alu);
            v2f = fwd(bypass_alu_2, bypass_mem_2, VSR2, m_alu);
            o2  = E_Control[0] ? v2f : sx(int'(IR[4:0]), 5);
            case (int'(E_Control[5:4]))
                0: res = 16'(int'(o1) + int'(o2));
                1: res = o1 & o2;
                2: res = ~o1;
                default: res = 16'h0000;
            endcase
            case (int'(E_Control[3:2]))
                0: addr = sx(int'(IR[10:0]), 11);
                1: addr = sx(int'(IR[8:0]), 9);
                2: addr = sx(int'(IR[5:0]), 6);
                default: addr = 16'h0000;
            endcase
            base = E_Control[1] ? npc_in : o1;
            opc  = int'(IR[15:12]);
            if (opc % 4 == 1) m_alu = res;
            m_pc    = 16'(int'(addr) + int'(base));
            m_mdata = v2f;
            m_nzp   = (opc == 0) ? IR[11:9] : ((opc == 12) ? 3'b111 : 3'b000);
            m_dr    = IR[11:9];
            m_ir    = IR;
            m_w     = W_Control_in;
            m_mc    = Mem_Control_in;
        end
    endtask

    task automatic check_all();
        check("aluout", aluout, m_alu);
        check("pcout", pcout, m_pc);
        check("M_Data", M_Data, m_mdata);
        check("NZP", 16'(NZP), 16'(m_nzp));
        check("dr", 16'(dr), 16'(m_dr));
        check("IR_Exec", IR_Exec, m_ir);
        check("W_Control_out", 16'(W_Control_out), 16'(m_w));
        check("Mem_Control_out", 16'(Mem_Control_out), 16'(m_mc));
    endtask

    task automatic check_src();
        int opc;
        opc = int'(IR[15:12]);
        check("sr1", 16'(sr1), 16'(IR[8:6]));
        check("sr2", 16'(sr2), (opc % 4 == 3) ? 16'(IR[11:9]) : 16'(IR[2:0]));
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input logic [15:0] ir, input logic [5:0] ec, input logic [15:0] v1,
                         input logic [15:0] v2, input logic [15:0] npc);
        IR = ir; E_Control = ec; VSR1 = v1; VSR2 = v2; npc_in = npc;
    endtask

    logic [15:0] hold_alu, hold_pc, exp_fwd;

    initial begin
        reset = 1'b1; enable_execute = 1'b1;
        drive(16'h0000, 6'b0, 16'h0, 16'h0, 16'h0);
        W_Control_in = 2'd0; Mem_Control_in = 1'b0; Mem_Bypass_Val = 16'h0;
        bypass_alu_1 = 0; bypass_alu_2 = 0; bypass_mem_1 = 0; bypass_mem_2 = 0;
        m_alu = 16'hxxxx;
        tick();
        check("reset_aluout", aluout, 16'h0000);
        check("reset_pcout", pcout, 16'h0000);
        reset = 1'b0;

        // ADD register form
        drive(16'h1642, 6'b000001, 16'd5, 16'd7, 16'h0);
        #1 check("add_sr1", 16'(sr1), 16'd1);
        check("add_sr2", 16'(sr2), 16'd2);
        tick();
        check("add_reg", aluout, 16'd12);
        check("add_dr", 16'(dr), 16'd3);

        // ADD immediate -1
        drive(16'h127F, 6'b000000, 16'd0, 16'h0, 16'h0);
        tick();
        check("add_imm", aluout, 16'hFFFF);

        // BRnzp
        drive(16'h0E05, 6'b000110, 16'h0, 16'h0, 16'h3001);
        tick();
        check("br_pc", pcout, 16'h3006);
        check("br_nzp", 16'(NZP), 16'h0007);
        check("br_alu_hold", aluout, 16'hFFFF);

        // LDR
        drive(16'h64FE, 6'b001000, 16'h4000, 16'h0, 16'h0);
        W_Control_in = 2'd1;
        tick();
        check("ldr_pc", pcout, 16'h3FFE);
        check("ldr_w", 16'(W_Control_out), 16'd1);

        // STR: source register from IR[11:9]
        W_Control_in = 2'd0;
        drive(16'h7A42, 6'b001000, 16'h1000, 16'hBEEF, 16'h0);
        #1 check("str_sr2", 16'(sr2), 16'd5);
        tick();
        check("str_mdata", M_Data, 16'hBEEF);

        // Forwarding onto op1
        drive(16'h1642, 6'b000001, 16'd5, 16'd7, 16'h0);
        tick();
        drive(16'h1260, 6'b000000, 16'd0, 16'd0, 16'h0);
        Mem_Bypass_Val = 16'h0055; bypass_alu_1 = 1; bypass_mem_1 = 1;
`ifdef EXEC_BYPASS_EN
        exp_fwd = 16'd12;
`else
        exp_fwd = 16'd0;
`endif
        tick();
        check("fwd_both", aluout, exp_fwd);
        bypass_alu_1 = 0;
`ifdef EXEC_BYPASS_EN
        exp_fwd = 16'h0055;
`else
        exp_fwd = 16'd0;
`endif
        tick();
        check("fwd_mem", aluout, exp_fwd);
        bypass_mem_1 = 0;

        // Stall for three cycles with changing inputs
        hold_alu = m_alu; hold_pc = m_pc;
        enable_execute = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(16'($urandom), 6'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            tick();
        end
        check("stall_alu", aluout, hold_alu);
        check("stall_pc", pcout, hold_pc);

        // Reset with enable high
        enable_execute = 1'b1; reset = 1'b1;
        drive(16'h1642, 6'b000001, 16'd5, 16'd7, 16'h0);
        tick();
        check("rst_en_alu", aluout, 16'h0000);
        check("rst_en_ir", IR_Exec, 16'h0000);
        reset = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            @(negedge clock);
            reset          = ($urandom_range(0, 31) == 0);
            enable_execute = ($urandom_range(0, 3) != 0);
            drive(16'($urandom), 6'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            W_Control_in   = 2'($urandom);
            Mem_Control_in = 1'($urandom);
            Mem_Bypass_Val = 16'($urandom);
            bypass_alu_1 = 1'($urandom); bypass_alu_2 = 1'($urandom);
            bypass_mem_1 = 1'($urandom); bypass_mem_2 = 1'($urandom);
            #1 check_src();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
